// File: rtl/mem_responder_if.sv
// Processor-to-memory request/response bus for mem_responder.
// The processor control unit is the master; the memory responder is the slave.
interface mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  READ;
  logic                  WRITE;
  logic [25:0]           ADDR;
  logic [DATA_WIDTH-1:0] DATA_W;
  logic [DATA_WIDTH-1:0] DATA_R;
  logic                  READY;
  logic                  ERR;

  modport master (
    output READ,
    output WRITE,
    output ADDR,
    output DATA_W,
    input  DATA_R,
    input  READY,
    input  ERR
  );

  modport slave (
    input  READ,
    input  WRITE,
    input  ADDR,
    input  DATA_W,
    output DATA_R,
    output READY,
    output ERR
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder. Captures a level-signalled READ/WRITE
// request, waits WAIT_STATES cycles, performs the access with the captured
// values, pulses READY for one cycle and then waits for the request to drop
// to a no-op before accepting another one.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic           CLK,
  input  logic           RST,
  mem_responder_if.slave bus
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);
  localparam bit          NO_WAIT  = (WAIT_STATES == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic                    w_capture;
  logic                    w_req_vld;

  logic                    r_op_read;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_data_r;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_out_of_range;
  logic                    w_do_read;
  logic                    w_do_write;

  // 00 and 11 are both no-ops; only a single asserted line is a request.
  assign w_req_vld      = bus.READ ^ bus.WRITE;
  assign w_out_of_range = |bus.ADDR[25:ADDR_WIDTH];

  // Access strobes: only the ACCESS state touches storage or DATA_R.
  assign w_do_read  = (r_state == S_ACCESS) &&  r_op_read;
  assign w_do_write = (r_state == S_ACCESS) && !r_op_read && !r_err;

  // State and wait-counter register; reset returns to IDLE and drops any
  // access that has not reached ACCESS yet.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic for the request/wait/access/handshake sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_vld) begin
          w_capture = 1'b1;
          if (NO_WAIT) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // The last wait cycle is the one where the counter reads 1.
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        // A held request must not retrigger; wait for a no-op first.
        if (!w_req_vld) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Request capture; after this edge the bus inputs are no longer looked at.
  always_ff @(posedge CLK) begin
    if (w_capture) begin
      r_op_read <= bus.READ;
      r_addr    <= bus.ADDR[ADDR_WIDTH-1:0];
      r_err     <= w_out_of_range;
      r_wdata   <= bus.DATA_W;
    end
  end

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (w_do_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Read data register; holds its value until the next completed read.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data_r <= '0;
    end else if (w_do_read) begin
      r_data_r <= r_err ? '0 : r_mem[r_addr];
    end
  end

  assign bus.DATA_R = r_data_r;
  assign bus.READY  = (r_state == S_DONE);
  assign bus.ERR    = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 wait states and 0 wait states)
// driven with identical bus traffic, each checked against its own
// behavioural memory model.
module tb_mem_responder;

  logic        CLK;
  logic        RST;
  logic        r_read;
  logic        r_write;
  logic [25:0] r_addr;
  logic [31:0] r_wdata;

  int n_checks;
  int n_errors;

  int          ws [2];
  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];
  logic [31:0] exp_dr [2];
  bit          dr_known [2];

  mem_responder_if #(.DATA_WIDTH(32)) bus_a ();
  mem_responder_if #(.DATA_WIDTH(32)) bus_b ();

  assign bus_a.READ   = r_read;
  assign bus_a.WRITE  = r_write;
  assign bus_a.ADDR   = r_addr;
  assign bus_a.DATA_W = r_wdata;
  assign bus_b.READ   = r_read;
  assign bus_b.WRITE  = r_write;
  assign bus_b.ADDR   = r_addr;
  assign bus_b.DATA_W = r_wdata;

  mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(2)) u_dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a)
  );

  mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic mdl_has(input int d, input int a);
    return (d == 0) ? mem_a.exists(a) : mem_b.exists(a);
  endfunction

  function automatic logic [31:0] mdl_get(input int d, input int a);
    return (d == 0) ? mem_a[a] : mem_b[a];
  endfunction

  task automatic mdl_put(input int d, input int a, input logic [31:0] v);
    if (d == 0) mem_a[a] = v;
    else        mem_b[a] = v;
  endtask

  // One bus transaction, started and ended at a falling edge. The request is
  // held for 'hold' cycles and then dropped to a no-op with scrambled
  // address/data, followed by enough idle cycles for both responders to return
  // to idle.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [25:0] addr, input logic [31:0] wd, input int hold);
    int          first [2];
    int          cnt   [2];
    int          stray [2];
    logic [31:0] dr_at [2];
    logic        err_at[2];
    logic        rdy   [2];
    logic        er    [2];
    logic [31:0] dr    [2];
    logic        vld;
    logic        oor;
    int          a;
    vld = rd ^ wr;
    oor = |addr[25:10];
    a   = int'(addr[9:0]);
    for (int d = 0; d < 2; d++) begin
      first[d] = -1; cnt[d] = 0; stray[d] = 0; dr_at[d] = '0; err_at[d] = 1'b0;
    end
    r_read = rd; r_write = wr; r_addr = addr; r_wdata = wd;
    for (int n = 1; n <= hold + 6; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      rdy[0] = bus_a.READY; er[0] = bus_a.ERR; dr[0] = bus_a.DATA_R;
      rdy[1] = bus_b.READY; er[1] = bus_b.ERR; dr[1] = bus_b.DATA_R;
      for (int d = 0; d < 2; d++) begin
        if (rdy[d]) begin
          cnt[d]++;
          if (first[d] < 0) begin
            first[d]  = n;
            dr_at[d]  = dr[d];
            err_at[d] = er[d];
          end
        end else if (er[d]) begin
          stray[d]++;
        end
      end
      if (n == hold) begin
        r_read = 1'b0; r_write = 1'b0; r_addr = 26'($urandom); r_wdata = $urandom;
      end
    end
    for (int d = 0; d < 2; d++) begin
      string t;
      t = $sformatf("%s.%s", tag, (d == 0) ? "ws2" : "ws0");
      chk({t, ".pulses"}, 32'(cnt[d]), vld ? 32'd1 : 32'd0);
      chk({t, ".err_stray"}, 32'(stray[d]), 32'd0);
      if (vld) begin
        chk({t, ".latency"}, 32'(first[d]), 32'(ws[d] + 2));
        chk({t, ".err"}, {31'd0, err_at[d]}, {31'd0, oor});
        if (rd) begin
          if (oor) begin
            exp_dr[d] = '0; dr_known[d] = 1'b1;
          end else if (mdl_has(d, a)) begin
            exp_dr[d] = mdl_get(d, a); dr_known[d] = 1'b1;
          end else begin
            dr_known[d] = 1'b0;
          end
        end else if (!oor) begin
          mdl_put(d, a, wd);
        end
        if (dr_known[d]) chk({t, ".data_ready"}, dr_at[d], exp_dr[d]);
      end
      if (dr_known[d]) chk({t, ".data_hold"}, dr[d], exp_dr[d]);
    end
  endtask

  // Reset asserted asynchronously 'k' edges after a write is sampled.
  // The write survives only if its ACCESS edge already happened.
  task automatic reset_mid_write(input logic [25:0] addr, input logic [31:0] wd, input int k);
    r_read = 1'b0; r_write = 1'b1; r_addr = addr; r_wdata = wd;
    for (int e = 0; e < k; e++) @(posedge CLK);
    #2 RST = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (k >= ws[d] + 2 && !(|addr[25:10])) mdl_put(d, int'(addr[9:0]), wd);
      exp_dr[d] = '0; dr_known[d] = 1'b1;
    end
    r_write = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      chk("rst_mid.ws2.ready", {31'd0, bus_a.READY}, 32'd0);
      chk("rst_mid.ws0.ready", {31'd0, bus_b.READY}, 32'd0);
      chk("rst_mid.ws2.data", bus_a.DATA_R, 32'd0);
      chk("rst_mid.ws0.data", bus_b.DATA_R, 32'd0);
    end
    RST = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      chk("rst_rel.ws2.ready", {31'd0, bus_a.READY}, 32'd0);
    end
  endtask

  initial begin
    logic [25:0] ra;
    int          op;
    n_checks = 0;
    n_errors = 0;
    ws[0] = 2;
    ws[1] = 0;
    exp_dr[0] = '0; exp_dr[1] = '0;
    dr_known[0] = 1'b1; dr_known[1] = 1'b1;

    // Reset held with a read request present: nothing may respond.
    RST = 1'b0;
    r_read = 1'b1; r_write = 1'b0; r_addr = 26'h5; r_wdata = 32'h0;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      chk("reset.ws2.ready", {31'd0, bus_a.READY}, 32'd0);
      chk("reset.ws2.err",   {31'd0, bus_a.ERR},   32'd0);
      chk("reset.ws2.data",  bus_a.DATA_R,         32'd0);
      chk("reset.ws0.ready", {31'd0, bus_b.READY}, 32'd0);
      chk("reset.ws0.err",   {31'd0, bus_b.ERR},   32'd0);
      chk("reset.ws0.data",  bus_b.DATA_R,         32'd0);
    end
    r_read = 1'b0;
    RST = 1'b1;
    @(negedge CLK);

    // Write then read back.
    do_req("wr_5",   1'b0, 1'b1, 26'h005, 32'hDEADBEEF, 5);
    do_req("rd_5",   1'b1, 1'b0, 26'h005, 32'h0,        5);
    do_req("wr_0",   1'b0, 1'b1, 26'h000, 32'h00001234, 3);
    do_req("wr_7",   1'b0, 1'b1, 26'h007, 32'h0BADC0DE, 1);

    // Held read gives a single pulse; a fresh read gives another.
    do_req("held_rd", 1'b1, 1'b0, 26'h005, 32'h0, 12);
    do_req("rd_5b",   1'b1, 1'b0, 26'h005, 32'h0, 4);

    // Both lines high is a no-op and must not write.
    do_req("noop11",  1'b1, 1'b1, 26'h005, 32'h12345678, 8);
    do_req("rd_5c",   1'b1, 1'b0, 26'h005, 32'h0, 4);

    // Out-of-range accesses.
    do_req("oor_wr",  1'b0, 1'b1, 26'h0000400, 32'hCAFEF00D, 5);
    do_req("rd_0",    1'b1, 1'b0, 26'h000, 32'h0, 5);
    do_req("oor_rd",  1'b1, 1'b0, 26'h0000400, 32'h0, 5);
    do_req("oor_rd_hi", 1'b1, 1'b0, 26'h2000007, 32'h0, 2);

    // Reset during the wait phase of a write.
    reset_mid_write(26'h007, 32'h11111111, 2);
    do_req("rd_7",    1'b1, 1'b0, 26'h007, 32'h0, 5);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      ra = 26'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra = ra | (26'd1 << $urandom_range(10, 25));
      case (op)
        0:       do_req($sformatf("rnd%0d_n00", i), 1'b0, 1'b0, ra, $urandom, int'($urandom_range(1, 9)));
        1:       do_req($sformatf("rnd%0d_n11", i), 1'b1, 1'b1, ra, $urandom, int'($urandom_range(1, 9)));
        2, 3, 4: do_req($sformatf("rnd%0d_wr", i),  1'b0, 1'b1, ra, $urandom, int'($urandom_range(1, 9)));
        default: do_req($sformatf("rnd%0d_rd", i),  1'b1, 1'b0, ra, $urandom, int'($urandom_range(1, 9)));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
